// File: rtl/systolic_feeder.sv
// Feeder for systolic_array: buffers a weight tile and replays it in reverse, then streams
// diagonally skewed feature columns with result-slot sideband. Define FEEDER_PERF_EN for perf counters.
module systolic_feeder #(
  parameter int WIDTH      = 32,
  parameter int M_SIZE     = 16,
  parameter int RESULT_LAT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [WIDTH*M_SIZE-1:0] w_data,
  input  logic                    f_valid,
  output logic                    f_ready,
  input  logic [WIDTH*M_SIZE-1:0] f_data,
  input  logic                    f_last,
  output logic                    load_weight,
  output logic [WIDTH*M_SIZE-1:0] weight_out,
  output logic [WIDTH*M_SIZE-1:0] feature_out,
  output logic                    busy,
  output logic                    res_slot_valid,
  output logic                    res_slot_last,
  output logic [31:0]             perf_cols,
  output logic [31:0]             perf_bubbles
);
  localparam int DW  = WIDTH * M_SIZE;
  localparam int K_W = $clog2(M_SIZE);
  localparam logic [K_W-1:0] K_LAST  = K_W'(M_SIZE - 1);
  localparam logic [K_W-1:0] K_DRAIN = K_W'(M_SIZE - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WCAP   = 3'd1,
    WISSUE = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t          state_r;
  logic [K_W-1:0]  k_r;
  logic [DW-1:0]   wbuf_r [M_SIZE];
  logic            w_ready_r;
  logic            f_ready_r;
  logic            busy_r;
  logic            load_weight_r;
  logic [DW-1:0]   weight_out_r;
  logic [1:0]      sb_r [RESULT_LAT+1];

  logic            w_hs_s;
  logic            f_hs_s;
  logic [DW-1:0]   slot_s;
  logic [1:0]      sb_in_s;

  // Handshakes and the slot entering the skew this cycle (zero unless a column is accepted)
  always_comb begin
    w_hs_s  = w_valid && w_ready_r;
    f_hs_s  = f_valid && f_ready_r;
    slot_s  = '0;
    sb_in_s = 2'b00;
    if (f_hs_s) begin
      slot_s  = f_data;
      sb_in_s = {1'b1, f_last};
    end else begin
      slot_s  = '0;
      sb_in_s = 2'b00;
    end
  end

  // Control FSM; outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      k_r           <= '0;
      w_ready_r     <= 1'b0;
      f_ready_r     <= 1'b0;
      busy_r        <= 1'b0;
      load_weight_r <= 1'b0;
      weight_out_r  <= '0;
      for (int i = 0; i < M_SIZE; i++) wbuf_r[i] <= '0;
    end else begin
      load_weight_r <= 1'b0;
      weight_out_r  <= '0;
      case (state_r)
        IDLE: begin
          w_ready_r <= 1'b1;
          f_ready_r <= 1'b0;
          busy_r    <= 1'b0;
          if (w_hs_s) begin
            wbuf_r[0] <= w_data;
            k_r       <= K_W'(1);
            busy_r    <= 1'b1;
            state_r   <= WCAP;
          end
        end
        WCAP: begin
          if (w_hs_s) begin
            wbuf_r[k_r] <= w_data;
            if (k_r == K_LAST) begin
              // The last row goes straight to weight_out so replay starts with WISSUE itself
              state_r       <= WISSUE;
              k_r           <= '0;
              w_ready_r     <= 1'b0;
              load_weight_r <= 1'b1;
              weight_out_r  <= w_data;
            end else begin
              k_r <= k_r + K_W'(1);
            end
          end
        end
        WISSUE: begin
          if (k_r == K_LAST) begin
            state_r   <= STREAM;
            k_r       <= '0;
            f_ready_r <= 1'b1;
          end else begin
            load_weight_r <= 1'b1;
            weight_out_r  <= wbuf_r[K_DRAIN - k_r];
            k_r           <= k_r + K_W'(1);
          end
        end
        STREAM: begin
          if (f_hs_s && f_last) begin
            state_r   <= DRAIN;
            k_r       <= '0;
            f_ready_r <= 1'b0;
          end
        end
        DRAIN: begin
          if (k_r == K_DRAIN) begin
            state_r   <= IDLE;
            k_r       <= '0;
            w_ready_r <= 1'b1;
            busy_r    <= 1'b0;
          end else begin
            k_r <= k_r + K_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          k_r       <= '0;
          w_ready_r <= 1'b0;
          f_ready_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < M_SIZE; c++) begin : g_lane
    logic [WIDTH-1:0] pipe_r [c+1];
    // Lane c delay line: c+1 registers so the array sees the diagonal wavefront
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= c; j++) pipe_r[j] <= '0;
      end else begin
        pipe_r[0] <= slot_s[c*WIDTH +: WIDTH];
        for (int j = 1; j <= c; j++) pipe_r[j] <= pipe_r[j-1];
      end
    end
    assign feature_out[c*WIDTH +: WIDTH] = pipe_r[c];
  end

  // Slot sideband pipeline; free-running so results drain while the next tile loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j <= RESULT_LAT; j++) sb_r[j] <= 2'b00;
    end else begin
      sb_r[0] <= sb_in_s;
      for (int j = 1; j <= RESULT_LAT; j++) sb_r[j] <= sb_r[j-1];
    end
  end

`ifdef FEEDER_PERF_EN
  logic [31:0] perf_cols_r;
  logic [31:0] perf_bubbles_r;
  logic        wissue_entry_s;

  assign wissue_entry_s = (state_r == WCAP) && w_hs_s && (k_r == K_LAST);

  // Saturating per-tile counters of accepted columns and bubble slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cols_r    <= 32'd0;
      perf_bubbles_r <= 32'd0;
    end else if (wissue_entry_s) begin
      perf_cols_r    <= 32'd0;
      perf_bubbles_r <= 32'd0;
    end else begin
      if (f_hs_s && (perf_cols_r != 32'hFFFF_FFFF)) perf_cols_r <= perf_cols_r + 32'd1;
      if (f_ready_r && !f_valid && (perf_bubbles_r != 32'hFFFF_FFFF))
        perf_bubbles_r <= perf_bubbles_r + 32'd1;
    end
  end

  assign perf_cols    = perf_cols_r;
  assign perf_bubbles = perf_bubbles_r;
`else
  assign perf_cols    = 32'd0;
  assign perf_bubbles = 32'd0;
`endif

  assign w_ready        = w_ready_r;
  assign f_ready        = f_ready_r;
  assign busy           = busy_r;
  assign load_weight    = load_weight_r;
  assign weight_out     = weight_out_r;
  assign res_slot_valid = sb_r[RESULT_LAT][1];
  assign res_slot_last  = sb_r[RESULT_LAT][0];

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage for systolic_array. It directly drives the array's load_weight, weight_in and feature_in pins.
- Accepts one weight tile as M_SIZE row vectors over a valid/ready handshake, buffers it, and replays the rows in reverse order while load_weight is high.
- Then accepts feature columns over a second valid/ready handshake and applies the diagonal skew: lane c is delayed by c cycles.
- Flushes with zeros at the end of the stream and emits slot-valid sideband signals aligned to the array's result_out.

Parameters:
- WIDTH, 32, bits per element.
- M_SIZE, 16, array dimension (lanes), >=2.
- RESULT_LAT, 16, cycles from a column slot entering lane 0 of feature_out to its lane-0 result on result_out.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- w_valid  in  1  weight row valid.
- w_ready  out  1  weight row accepted when w_valid && w_ready.
- w_data  in  WIDTH*M_SIZE  weight row; lane c at [c*WIDTH +: WIDTH]. Row 0 arrives first.
- f_valid  in  1  feature column valid.
- f_ready  out  1  feature column accept.
- f_data  in  WIDTH*M_SIZE  feature column; lane c = feature[c][col].
- f_last  in  1  marks the final column of the stream.
- load_weight  out  1  to array.
- weight_out  out  WIDTH*M_SIZE  to array weight_in.
- feature_out  out  WIDTH*M_SIZE  to array feature_in (skewed).
- busy  out  1  high in any state other than IDLE.
- res_slot_valid  out  1  lane-0 result on result_out belongs to a real column.
- res_slot_last  out  1  lane-0 result belongs to the f_last column.
- perf_cols  out  32  see Optional Feature.
- perf_bubbles  out  32  see Optional Feature.

Behaviour:
- Reset:
  - All outputs 0.
  - FSM goes to IDLE.
  - Weight buffer, skew registers, slot pipelines and counters cleared.
  - Reset asserted mid-operation aborts immediately; no partial replay afterwards.
- FSM states: IDLE, WCAP, WISSUE, STREAM, DRAIN.
  - IDLE: w_ready=1. On a w_valid handshake, store row 0 and go to WCAP.
  - WCAP: w_ready=1. Capture rows 1..M_SIZE-1 into buf[k]. On the handshake of row M_SIZE-1, go to WISSUE, reset row counter k=0, w_ready=0.
  - WISSUE: exactly M_SIZE cycles, registered outputs.
    - load_weight=1.
    - weight_out=buf[M_SIZE-1-k], k incrementing.
    - feature_out=0.
    - Then go to STREAM.
  - STREAM: f_ready=1 every cycle, no backpressure.
    - Each cycle a slot enters the skew: the accepted f_data if f_valid, else all-zero (bubble).
    - On a handshake with f_last=1, go to DRAIN.
  - DRAIN: exactly M_SIZE-1 cycles of zero slots, f_ready=0. Then go to IDLE.
- Skew:
  - Lane 0 is registered once; lane c passes through c+1 registers total.
  - So feature_out lane c in cycle t = slot (t-1-c). Out-of-range slots read as 0.
  - The first slot reaches feature_out lane 0 in the cycle after acceptance.
  - The last slot's lane M_SIZE-1 exits exactly at the end of DRAIN.
- load_weight and weight_out are registered. load_weight is never high while any nonzero value is present in the skew.
- Slot sideband:
  - A {valid, last} bit pair enters a shift pipeline with each slot; bubbles enter as {0,0}.
  - Pipeline depth is 1+RESULT_LAT.
  - res_slot_valid / res_slot_last are the pipeline output.
  - The pipeline keeps shifting in IDLE/WCAP/WISSUE, so results drain correctly while the next tile's weights load.
- Data is passed unmodified; no arithmetic.
- w_valid is ignored in WISSUE/STREAM/DRAIN (w_ready=0). f_valid is ignored outside STREAM.
- f_last on the very first column yields a one-column stream plus the M_SIZE-1 drain cycles.

Optional Feature:
- Macro: FEEDER_PERF_EN.
- Defined:
  - perf_cols counts feature handshakes.
  - perf_bubbles counts STREAM cycles with f_valid=0.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on rst and on entry to WISSUE.
- Undefined: both ports are tied to 0 and no counter registers are built.

Test Plan:
- M_SIZE=4, WIDTH=32, RESULT_LAT=4; rows {1,2,3,4},{5..8},{9..12},{13..16} -> load_weight high 4 cycles with weight_out rows 13..16, 9..12, 5..8, 1..4 in that order; busy=1 from the first handshake.
- After load, stream columns A={1,2,3,4} and B={5,6,7,8} (B has f_last) back to back -> feature_out lane0: 1,5,0; lane1: 0,2,6; lane3 values 4 then 8 at t+3 and t+4; DRAIN lasts 3 cycles, then IDLE.
- In STREAM, apply f_valid pattern 1,0,1(last) -> bubble slot is all zeros; res_slot_valid reads 1,0,1 exactly 5 cycles after the respective accepts; res_slot_last=1 on the third only.
- Assert rst for 1 cycle in the middle of WISSUE (k=2) -> all outputs 0 next edge; a fresh weight tile afterwards replays correctly.
- With FEEDER_PERF_EN defined, 10 columns with 3 bubbles -> perf_cols=10, perf_bubbles=3; with the macro undefined, both read 0.
- w_valid held high throughout STREAM -> w_ready=0 and no buffer change; the next tile loads only after IDLE.
